// File: rtl/sensor_pattern_gen.sv
// sensor_pattern_gen: drives the two photo-sensor beams (a, b) through one
// complete car passage (entry or exit) with a programmable dwell per phase.
// Optional build macro SENSOR_GEN_COUNT_EN adds a saturating occupancy counter
// that tracks completed entries minus completed exits.
module sensor_pattern_gen #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done
`ifdef SENSOR_GEN_COUNT_EN
  ,
  output logic [CNT_W-1:0]   occupancy
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    P3   = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic [DWELL_W-1:0] dwell_q;
  logic               dir_q, dir_nx;
  logic               accept;

  // Counter reload value: a dwell of zero still holds the phase for one cycle.
  function automatic logic [DWELL_W-1:0] load_val(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  // Beam pattern for a state; P1 and P3 swap with direction so that exactly
  // one beam toggles per phase step.
  function automatic logic [1:0] beams(input state_t s, input logic d);
    logic [1:0] ab;
    case (s)
      P1:      ab = d ? 2'b01 : 2'b10;
      P2:      ab = 2'b11;
      P3:      ab = d ? 2'b10 : 2'b01;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  // abort in IDLE masks a simultaneous start.
  assign accept = (state == IDLE) && start && !abort;

  // Next-state, dwell countdown and direction latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dir_nx   = dir_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = P1;
          dir_nx   = dir;
          cnt_nx   = load_val(dwell);
        end
      end
      P1, P2, P3: begin
        if (abort) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == '0) begin
          cnt_nx = load_val(dwell_q);
          case (state)
            P1:      state_nx = P2;
            P2:      state_nx = P3;
            default: begin
              state_nx = GAP;
              cnt_nx   = '0;
            end
          endcase
        end else begin
          cnt_nx = cnt - DWELL_W'(1);
        end
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register; outputs are decoded from the next state so they are
  // registered yet line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      dir_q <= 1'b0;
      a     <= 1'b0;
      b     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      dir_q    <= dir_nx;
      {a, b}   <= beams(state_nx, dir_nx);
      busy     <= (state_nx != IDLE);
      done     <= (state_nx == GAP);
    end
  end

  // Dwell is only consulted after it has been captured with an accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      dwell_q <= dwell;
    end
  end

`ifdef SENSOR_GEN_COUNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  // Occupancy changes together with the done pulse; aborted runs never reach GAP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupancy <= '0;
    end else if (state_nx == GAP) begin
      occupancy <= dir_q ? sat_dec(occupancy) : sat_inc(occupancy);
    end
  end
`else
  // CNT_W only sizes the occupancy counter, which this build leaves out.
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_sensor_pattern_gen.sv
// Testbench for sensor_pattern_gen: scoreboard of expected {a,b,busy,done}
// per cycle, plus a small two-beam passage decoder model.
`timescale 1ns/1ps
module tb_sensor_pattern_gen;

`ifdef SENSOR_GEN_COUNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic       start   = 1'b0;
  logic       dir     = 1'b0;
  logic       abort   = 1'b0;
  logic [7:0] dwell   = 8'd0;
  logic       a, b, busy, done;
`ifdef SENSOR_GEN_COUNT_EN
  logic [CW-1:0] occupancy;
`endif

  int total = 0;
  int bad   = 0;

  // Expected {a, b, busy, done}, one entry per clock cycle.
  logic [3:0] exp_q[$];

  // Decoder model: remembers the last three distinct beam patterns.
  logic [1:0] last1 = 2'b00, last2 = 2'b00, last3 = 2'b00;
  logic       dec_y;

  sensor_pattern_gen #(.DWELL_W(8), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .dir      (dir),
    .dwell    (dwell),
    .abort    (abort),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done)
`ifdef SENSOR_GEN_COUNT_EN
    ,
    .occupancy(occupancy)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if ({a, b} != last1) begin
      last3 <= last2;
      last2 <= last1;
      last1 <= {a, b};
    end
  end

  assign dec_y = ({a, b} == 2'b00) &&
                 (({last3, last2, last1} == 6'b10_11_01) ||
                  ({last3, last2, last1} == 6'b01_11_10));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  function automatic void push_pass(input logic d, input int dw);
    int n;
    n = (dw == 0) ? 1 : dw;
    for (int i = 0; i < n; i++) exp_q.push_back({(d ? 2'b01 : 2'b10), 2'b10});
    for (int i = 0; i < n; i++) exp_q.push_back(4'b1110);
    for (int i = 0; i < n; i++) exp_q.push_back({(d ? 2'b10 : 2'b01), 2'b10});
    exp_q.push_back(4'b0011);
  endfunction

  task automatic test_reset();
    logic [3:0] e;
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({a, b, busy, done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_init got=%b exp=0000", {a, b, busy, done});
    end
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b1; dir = 1'b0; dwell = 8'd5;
    push_pass(1'b0, 5);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({a, b, busy, done} !== e) begin
        bad++;
        $display("FAIL reset_run cyc=%0d got=%b exp=%b", i, {a, b, busy, done}, e);
      end
    end
    exp_q.delete();
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({a, b, busy, done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async got=%b exp=0000", {a, b, busy, done});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({a, b, busy, done} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=0000", i, {a, b, busy, done});
      end
    end
  endtask

  task automatic test_entry();
    logic [3:0] e;
    int n, busy_cnt;
    busy_cnt = 0;
    start = 1'b1; dir = 1'b0; dwell = 8'd3;
    push_pass(1'b0, 3);
    exp_q.push_back(4'b0000);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      if (busy) busy_cnt++;
      total++;
      if ({a, b, busy, done} !== e) begin
        bad++;
        $display("FAIL entry cyc=%0d got=%b exp=%b", i, {a, b, busy, done}, e);
      end
      if (e[0]) begin
        total++;
        if (dec_y !== 1'b1) begin
          bad++;
          $display("FAIL entry_decoder_y got=%b exp=1", dec_y);
        end
      end
    end
    total++;
    if (busy_cnt != 10) begin
      bad++;
      $display("FAIL entry_busy_len got=%0d exp=10", busy_cnt);
    end
  endtask

  task automatic test_exit();
    logic [3:0] e;
    int n, busy_cnt;
    busy_cnt = 0;
    start = 1'b1; dir = 1'b1; dwell = 8'd0;
    push_pass(1'b1, 0);
    exp_q.push_back(4'b0000);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      if (busy) busy_cnt++;
      total++;
      if ({a, b, busy, done} !== e) begin
        bad++;
        $display("FAIL exit cyc=%0d got=%b exp=%b", i, {a, b, busy, done}, e);
      end
      if (e[0]) begin
        total++;
        if (dec_y !== 1'b1) begin
          bad++;
          $display("FAIL exit_decoder_y got=%b exp=1", dec_y);
        end
      end
    end
    total++;
    if (busy_cnt != 4) begin
      bad++;
      $display("FAIL exit_busy_len got=%0d exp=4", busy_cnt);
    end
  endtask

  task automatic test_abort();
    logic [3:0] e;
    int n;
    // Abort in the second P2 cycle of an entry with dwell=4.
    start = 1'b1; dir = 1'b0; dwell = 8'd4;
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b1010);
    for (int i = 0; i < 2; i++) exp_q.push_back(4'b1110);
    for (int i = 0; i < 2; i++) exp_q.push_back(4'b0000);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({a, b, busy, done} !== e) begin
        bad++;
        $display("FAIL abort_p2 cyc=%0d got=%b exp=%b", i, {a, b, busy, done}, e);
      end
      if (i == 5) abort = 1'b1;
    end
    // abort and start together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; dwell = 8'd1;
    for (int i = 0; i < 2; i++) exp_q.push_back(4'b0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({a, b, busy, done} !== e) begin
        bad++;
        $display("FAIL abort_idle cyc=%0d got=%b exp=%b", i, {a, b, busy, done}, e);
      end
    end
    // A start pulse during P1 must not disturb the running exit.
    start = 1'b1; dir = 1'b1; dwell = 8'd2;
    push_pass(1'b1, 2);
    exp_q.push_back(4'b0000);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({a, b, busy, done} !== e) begin
        bad++;
        $display("FAIL ignored_start cyc=%0d got=%b exp=%b", i, {a, b, busy, done}, e);
      end
      if (i == 0) begin
        start = 1'b1; dir = 1'b0; dwell = 8'd7;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    int n, first_done, second_done;
    first_done = -1;
    second_done = -1;
    start = 1'b1; dir = 1'b0; dwell = 8'd2;
    push_pass(1'b0, 2);
    exp_q.push_back(4'b0000);
    push_pass(1'b0, 2);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (done) begin
        if (first_done < 0) first_done = i;
        else second_done = i;
      end
      total++;
      if ({a, b, busy, done} !== e) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, {a, b, busy, done}, e);
      end
      if (i == 8) start = 1'b0;
    end
    total++;
    if ((second_done - first_done) != 8) begin
      bad++;
      $display("FAIL b2b_done_spacing got=%0d exp=8", second_done - first_done);
    end
  endtask

`ifdef SENSOR_GEN_COUNT_EN
  task automatic test_count();
    logic [3:0]    e;
    logic [CW-1:0] occ_m;
    logic [CW-1:0] occ_q[$];
    logic [CW-1:0] eo;
    logic          d;
    int            n;
    occ_m = '0;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (occupancy !== '0) begin
      bad++;
      $display("FAIL count_reset got=%0d exp=0", occupancy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      d = (k >= 5);
      start = 1'b1; dir = d; dwell = 8'd0;
      push_pass(d, 0);
      exp_q.push_back(4'b0000);
      occ_m = d ? ((occ_m == '0) ? occ_m : occ_m - 1'b1)
                : ((occ_m == '1) ? occ_m : occ_m + 1'b1);
      occ_q.push_back(occ_m);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        start = 1'b0;
        e = exp_q.pop_front();
        total++;
        if ({a, b, busy, done} !== e) begin
          bad++;
          $display("FAIL count_pass k=%0d cyc=%0d got=%b exp=%b", k, i, {a, b, busy, done}, e);
        end
      end
      eo = occ_q.pop_front();
      total++;
      if (occupancy !== eo) begin
        bad++;
        $display("FAIL count_occ k=%0d got=%0d exp=%0d", k, occupancy, eo);
      end
    end
    // Aborted entry leaves the count alone.
    start = 1'b1; dir = 1'b0; dwell = 8'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (i == 1);
    end
    abort = 1'b0;
    total++;
    if (occupancy !== occ_m) begin
      bad++;
      $display("FAIL count_abort got=%0d exp=%0d", occupancy, occ_m);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_abort();
    test_back_to_back();
`ifdef SENSOR_GEN_COUNT_EN
    test_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
